// File: rtl/gray_key_lookup.sv
// gray_key_lookup: small key table with a two-stage lookup pipeline.
// Stage 1 captures which valid entries match the lookup key. Stage 2 picks the
// lowest matching index and converts it to a Gray or binary result code.
// Both stages use valid/ready flow control and can hold two results while the
// consumer stalls.
module gray_key_lookup #(
  parameter int NR_KEY     = 4,
  parameter int KEY_WIDTH  = 4,
  parameter int DATA_WIDTH = 2,
  parameter int GRAY_MODE  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [$clog2(NR_KEY)-1:0]   wr_idx,
  input  logic [KEY_WIDTH-1:0]        wr_key,
  input  logic                        wr_vld,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [KEY_WIDTH-1:0]        sel,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       out,
  output logic                        hit
);

  localparam int IDX_W = $clog2(NR_KEY);

  logic [NR_KEY-1:0]     entryVld_q, entryVld_d;
  logic [KEY_WIDTH-1:0]  entryKey_q [NR_KEY];
  logic [KEY_WIDTH-1:0]  entryKey_d [NR_KEY];

  logic                  s1Vld_q, s1Vld_d;
  logic [NR_KEY-1:0]     s1Match_q, s1Match_d;

  logic                  s2Vld_q, s2Vld_d;
  logic                  s2Hit_q, s2Hit_d;
  logic [DATA_WIDTH-1:0] s2Code_q, s2Code_d;

  logic [NR_KEY-1:0]     matchVec;
  logic                  encHit;
  logic [IDX_W-1:0]      encIdx;
  logic [DATA_WIDTH-1:0] encCode;
  logic                  s1Adv;
  logic                  s2Adv;

  // Stage 2 can take new data when it is empty or its result leaves this
  // cycle; stage 1 likewise when empty or moving into stage 2.
  assign s2Adv     = !s2Vld_q || out_ready;
  assign s1Adv     = !s1Vld_q || s2Adv;
  assign in_ready  = !rst && s1Adv;
  assign out_valid = s2Vld_q;
  assign out       = s2Code_q;
  assign hit       = s2Hit_q;

  // Table update: out-of-range indices leave the table untouched.
  always_comb begin
    entryVld_d = entryVld_q;
    entryKey_d = entryKey_q;
    if (wr_en && (int'(wr_idx) < NR_KEY)) begin
      entryVld_d[wr_idx] = wr_vld;
      entryKey_d[wr_idx] = wr_key;
    end
  end

  // Per-entry compare uses the registered table, so a same-cycle write is not seen.
  always_comb begin
    matchVec = '0;
    for (int i = 0; i < NR_KEY; i++) begin
      matchVec[i] = entryVld_q[i] && (entryKey_q[i] == sel);
    end
  end

  // Lowest-index priority encode of the stage-1 match vector plus code conversion.
  always_comb begin
    encHit = 1'b0;
    encIdx = '0;
    for (int i = NR_KEY - 1; i >= 0; i--) begin
      if (s1Match_q[i]) begin
        encHit = 1'b1;
        encIdx = IDX_W'(i);
      end
    end
    if (GRAY_MODE != 0) begin
      encCode = DATA_WIDTH'(encIdx ^ (encIdx >> 1));
    end else begin
      encCode = DATA_WIDTH'(encIdx);
    end
  end

  // Pipeline next state: each stage loads only when it is allowed to advance.
  always_comb begin
    s1Vld_d   = s1Vld_q;
    s1Match_d = s1Match_q;
    s2Vld_d   = s2Vld_q;
    s2Hit_d   = s2Hit_q;
    s2Code_d  = s2Code_q;
    if (s2Adv) begin
      s2Vld_d = s1Vld_q;
      if (s1Vld_q) begin
        s2Hit_d  = encHit;
        s2Code_d = encCode;
      end
    end
    if (s1Adv) begin
      s1Vld_d = in_valid;
      if (in_valid) begin
        s1Match_d = matchVec;
      end
    end
  end

  // Valid bits and pipeline registers; reset empties the table and drops in-flight lookups.
  always_ff @(posedge clk) begin
    if (rst) begin
      entryVld_q <= '0;
      s1Vld_q    <= 1'b0;
      s1Match_q  <= '0;
      s2Vld_q    <= 1'b0;
      s2Hit_q    <= 1'b0;
      s2Code_q   <= '0;
    end else begin
      entryVld_q <= entryVld_d;
      s1Vld_q    <= s1Vld_d;
      s1Match_q  <= s1Match_d;
      s2Vld_q    <= s2Vld_d;
      s2Hit_q    <= s2Hit_d;
      s2Code_q   <= s2Code_d;
    end
  end

  // Stored keys need no reset since an entry is only meaningful with its valid bit set.
  always_ff @(posedge clk) begin
    entryKey_q <= entryKey_d;
  end

endmodule

// File: tb/tb_gray_key_lookup.sv
// tb_gray_key_lookup: directed bench for gray_key_lookup with a table/queue
// reference model checked every cycle plus hand-computed literal expectations.
module tb_gray_key_lookup;

  localparam int NR_KEY = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [1:0] wr_idx;
  logic [3:0] wr_key;
  logic       wr_vld;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] sel;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out;
  logic       hit;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic       hitv;
    logic [1:0] code;
    int         acc;
  } exp_t;

  exp_t       q[$];
  logic       mv[NR_KEY];
  logic [3:0] mk[NR_KEY];

  gray_key_lookup #(
    .NR_KEY(4), .KEY_WIDTH(4), .DATA_WIDTH(2), .GRAY_MODE(1)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key),
    .wr_vld(wr_vld), .in_valid(in_valid), .in_ready(in_ready), .sel(sel),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .hit(hit)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [1:0] idx, input logic [3:0] key,
                               input logic vld, input logic iv, input logic [3:0] s,
                               input logic ordy);
    wr_en     = we;
    wr_idx    = idx;
    wr_key    = key;
    wr_vld    = vld;
    in_valid  = iv;
    sel       = s;
    out_ready = ordy;
  endtask

  // Reference lookup: first valid entry whose key equals s, reported as Gray code.
  function automatic exp_t modelLookup(input logic [3:0] s, input int c);
    exp_t e;
    bit   found;
    e.hitv = 1'b0;
    e.code = 2'd0;
    e.acc  = c;
    found  = 0;
    for (int i = 0; i < NR_KEY; i++) begin
      if (!found && mv[i] && mk[i] == s) begin
        found  = 1;
        e.hitv = 1'b1;
        e.code = 2'(i ^ (i >> 1));
      end
    end
    return e;
  endfunction

  // Every-cycle compare against the model; a result appears two cycles after acceptance.
  always @(negedge clk) begin
    logic expReady;
    logic expValid;
    cyc++;
    if (rst) begin
      checkOutput("in_ready_rst", in_ready, 1'b0);
      q.delete();
      for (int i = 0; i < NR_KEY; i++) mv[i] = 1'b0;
    end else begin
      expReady = !(q.size() == 2 && !out_ready);
      checkOutput("in_ready", in_ready, expReady);
      expValid = (q.size() > 0) && (cyc >= q[0].acc + 2);
      checkOutput("out_valid", out_valid, expValid);
      if (expValid) begin
        checkOutput("hit", hit, q[0].hitv);
        checkOutput("out", out, q[0].code);
        if (out_ready) void'(q.pop_front());
      end
      if (in_valid && expReady) q.push_back(modelLookup(sel, cyc));
      if (wr_en) begin
        mv[wr_idx] = wr_vld;
        mk[wr_idx] = wr_key;
      end
    end
  end

  task automatic writeKey(input logic [1:0] idx, input logic [3:0] key, input logic vld);
    applyStimulus(1'b1, idx, key, vld, 1'b0, 4'd0, 1'b1);
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // Single lookup with out_ready high: checks acceptance, 2-cycle latency and the literal result.
  task automatic lookupExpect(input string name, input logic [3:0] s, input logic eh, input logic [1:0] eo);
    sel      = s;
    in_valid = 1'b1;
    @(negedge clk);
    checkOutput({name, "_acc"}, in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wr_en    = 1'b0;
    @(negedge clk);
    checkOutput({name, "_lat1"}, out_valid, 1'b0);
    @(negedge clk);
    checkOutput({name, "_vld"}, out_valid, 1'b1);
    checkOutput({name, "_hit"}, hit, eh);
    checkOutput({name, "_out"}, out, eo);
    @(posedge clk); #1;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] streamSel [8];
    logic       streamRdy [8];
    streamSel = '{4'd5, 4'd9, 4'd3, 4'd7, 4'd5, 4'd0, 4'd9, 4'd3};
    streamRdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    rst = 1'b1;
    applyStimulus(1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready", in_ready, 1'b0);
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_hit", hit, 1'b0);
    checkOutput("rst_out", out, 2'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_in_ready", in_ready, 1'b1);
    checkOutput("post_rst_out_valid", out_valid, 1'b0);
    @(posedge clk); #1;

    // Empty table: miss.
    lookupExpect("lk0", 4'd0, 1'b0, 2'd0);

    // Load table and look up.
    writeKey(2'd0, 4'd5, 1'b1);
    writeKey(2'd1, 4'd9, 1'b1);
    writeKey(2'd2, 4'd3, 1'b1);
    writeKey(2'd3, 4'd9, 1'b1);
    lookupExpect("lk3", 4'd3, 1'b1, 2'd3);
    lookupExpect("lk9", 4'd9, 1'b1, 2'd1);

    // Stall: offer 3, 9, 5 with out_ready low.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel       = 4'd3;
    @(negedge clk);
    checkOutput("stall_acc3", in_ready, 1'b1);
    @(posedge clk); #1;
    sel = 4'd9;
    @(negedge clk);
    checkOutput("stall_acc9", in_ready, 1'b1);
    @(posedge clk); #1;
    sel = 4'd5;
    repeat (3) begin
      @(negedge clk);
      checkOutput("stall_full", in_ready, 1'b0);
      checkOutput("stall_out", out, 2'd3);
      checkOutput("stall_hit", hit, 1'b1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("rel_acc5", in_ready, 1'b1);
    checkOutput("rel_out0", out, 2'd3);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("rel_out1", out, 2'd1);
    checkOutput("rel_hit1", hit, 1'b1);
    @(negedge clk);
    checkOutput("rel_out2", out, 2'd0);
    checkOutput("rel_hit2", hit, 1'b1);
    @(posedge clk); #1;

    // Same-cycle write is not visible to the lookup.
    wr_en  = 1'b1;
    wr_idx = 2'd2;
    wr_key = 4'd7;
    wr_vld = 1'b1;
    lookupExpect("same_cyc", 4'd7, 1'b0, 2'd0);
    lookupExpect("after_wr", 4'd7, 1'b1, 2'd3);

    // Invalidate idx1: key 9 now resolves to idx3.
    writeKey(2'd1, 4'd9, 1'b0);
    lookupExpect("inval9", 4'd9, 1'b1, 2'd2);

    // Streaming with a stall pattern; the every-cycle compare does the checking.
    writeKey(2'd1, 4'd3, 1'b1);
    for (int i = 0; i < 8; i++) begin
      in_valid  = 1'b1;
      sel       = streamSel[i];
      out_ready = streamRdy[i];
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Reset with both stages full: nothing must come out afterwards.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel       = 4'd5;
    @(posedge clk); #1;
    sel = 4'd9;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("full_before_rst", in_ready, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("rst_flush_vld", out_valid, 1'b0);
      checkOutput("rst_flush_rdy", in_ready, 1'b1);
    end
    @(posedge clk); #1;
    lookupExpect("post_rst5", 4'd5, 1'b0, 2'd0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gray_key_lookup.md
GRAY_KEY_LOOKUP -- requirements
Module: gray_key_lookup

Interface
REQ-001 SHALL have parameter NR_KEY, default 4: number of key table entries; NR_KEY >= 2.
REQ-002 SHALL have parameter KEY_WIDTH, default 4: width of each stored key and of the lookup key.
REQ-003 SHALL have parameter DATA_WIDTH, default 2: result width; DATA_WIDTH >= clog2(NR_KEY).
REQ-004 SHALL have parameter GRAY_MODE, default 1: 1 = result is Gray code i ^ (i >> 1) of the matched index i; 0 = plain binary index.
REQ-005 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port wr_en, input, 1: table write strobe.
REQ-008 SHALL have port wr_idx, input, clog2(NR_KEY): entry to write.
REQ-009 SHALL have port wr_key, input, KEY_WIDTH: key value to store.
REQ-010 SHALL have port wr_vld, input, 1: 1 = mark entry valid, 0 = invalidate entry.
REQ-011 SHALL have port in_valid, input, 1: lookup request present.
REQ-012 SHALL have port in_ready, output, 1: block can accept a lookup this cycle.
REQ-013 SHALL have port sel, input, KEY_WIDTH: lookup key.
REQ-014 SHALL have port out_valid, output, 1: result present.
REQ-015 SHALL have port out_ready, input, 1: consumer accepts result this cycle.
REQ-016 SHALL have port out, output, DATA_WIDTH: result code, zero-extended.
REQ-017 SHALL have port hit, output, 1: 1 = key matched a valid entry.

Function
REQ-018 SHALL hold NR_KEY entries, each {valid, key}; write with wr_en=1 sets entry wr_idx to {wr_vld, wr_key} at the clock edge; wr_idx >= NR_KEY is ignored.
REQ-019 SHALL accept a lookup when in_valid && in_ready (handshake); out_valid/out/hit SHALL be presented until out_valid && out_ready.
REQ-020 SHALL use a 2-stage pipeline: stage 1 registers the per-entry match vector (entry valid && key == sel); stage 2 registers lowest-index priority encode, code conversion and hit.
REQ-021 SHALL give latency of exactly 2 cycles from acceptance to out_valid when out_ready stays 1; throughput 1 lookup/cycle.
REQ-022 SHALL compare against table contents before any write in the same cycle (a same-cycle write is not visible to that lookup).
REQ-023 SHALL, on multiple matches, return the lowest matching index.
REQ-024 SHALL, on no match, drive hit=0 and out=0.
REQ-025 SHALL advance each stage when it is empty or its contents move downstream in the same cycle; in_ready = stage 1 empty or stage 1 advancing.
REQ-026 SHALL, under out_ready=0, hold up to 2 results in flight without loss, duplication or reordering; in_ready SHALL drop to 0 when both stages are full.
REQ-027 SHALL keep out and hit stable while out_valid=1 and out_ready=0.
REQ-028 SHALL compute the result code in DATA_WIDTH bits; for GRAY_MODE=1, index 3 yields 2 and index 2 yields 3.

Reset
REQ-029 SHALL, while rst=1, clear all entry valid bits, both pipeline stages, out_valid=0, out=0, hit=0, in_ready=0.
REQ-030 SHALL, in the first cycle after rst falls, drive in_ready=1 and out_valid=0; in-flight lookups at reset SHALL be discarded, never emitted.

Verification (NR_KEY=4, KEY_WIDTH=4, DATA_WIDTH=2, GRAY_MODE=1)
REQ-031 SHALL cover: reset, lookup sel=0 -> 2 cycles later out_valid=1, hit=0, out=0.
REQ-032 SHALL cover: write idx0=5, idx1=9, idx2=3, idx3=9; lookup 3 -> hit=1, out=3; lookup 9 -> hit=1, out=1 (lowest index).
REQ-033 SHALL cover: out_ready=0, offer 3 back-to-back lookups (3, 9, 5) -> 2 accepted, in_ready=0; release -> results 3, 1, 0 in order with hit=1, then third accepted.
REQ-034 SHALL cover: same-cycle write idx2=7 and lookup 7 -> hit=0; next lookup 7 -> hit=1, out=3.
REQ-035 SHALL cover: invalidate idx1 (wr_vld=0), lookup 9 -> hit=1, out=2 (index 3).
REQ-036 SHALL cover: rst asserted with both stages full -> no out_valid after reset; lookup 5 -> hit=0.
